// File: rtl/ramb16_pkg.sv
// Shared types and constants for the RAMB16_S1 bit-serial byte reader.
package ramb16_pkg;

  localparam int RAMB16_S1_AW    = 14;
  localparam int RAMB16_S1_DEPTH = 16384;
  localparam int BYTE_BITS       = 8;
  localparam int NBYTES_W        = 12;
  localparam int BIT_CNT_W       = NBYTES_W + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Total bit reads for a command; 4095 bytes still fits in 15 bits.
  function automatic logic [BIT_CNT_W-1:0] total_bits(input logic [NBYTES_W-1:0] n);
    return {n, 3'b000};
  endfunction

endpackage

// File: rtl/ramb16_s1_byte_reader_bit_packer.sv
// Shifts returned RAM bits into bytes and presents them on a valid/ready output register.
module bit_packer
  import ramb16_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 dout_ready,
  output logic [BYTE_BITS-1:0] dout,
  output logic                 dout_valid
);

  logic [BYTE_BITS-1:0] sr;
  logic [BYTE_BITS-1:0] shifted;
  logic [2:0]           cnt;
  logic                 byte_done;

  always_comb begin
    shifted   = MSB_FIRST ? {sr[BYTE_BITS-2:0], bit_in} : {bit_in, sr[BYTE_BITS-1:1]};
    byte_done = bit_valid && (cnt == 3'(BYTE_BITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (bit_valid) begin
      sr  <= shifted;
      cnt <= cnt + 3'd1;
    end
  end

  // The upstream stall guarantees a completed byte only lands when the
  // register is empty or is being accepted on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (byte_done) begin
      dout       <= shifted;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ramb16_s1_byte_reader.sv
// Walks a bit range of a 16K x 1 RAMB16_S1, one read per cycle, and streams packed bytes.
module ramb16_s1_byte_reader
  import ramb16_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [RAMB16_S1_AW-1:0] base_addr,
  input  logic [NBYTES_W-1:0]     nbytes,
  output logic                    busy,
  output logic                    done,
  output logic [RAMB16_S1_AW-1:0] ram_addr,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic                    ram_ssr,
  output logic                    ram_di,
  input  logic                    ram_do,
  output logic [BYTE_BITS-1:0]    dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output state_t                  dbg_state
);

  // Output stream: a byte transfers on any rising edge where dout_valid and
  // dout_ready are both high; dout/dout_valid hold steady until then.

  state_t               state;
  state_t               next_state;
  logic                 busy_d;
  logic                 done_d;
  logic [BIT_CNT_W-1:0] bits_left;
  logic [2:0]           issue_idx;
  logic                 rd_pending;
  logic                 accept;
  logic                 issue_ok;
  logic                 issue;
  logic                 last_issue;
  logic                 final_hs;

  assign ram_we    = 1'b0;
  assign ram_ssr   = 1'b0;
  assign ram_di    = 1'b0;
  assign dbg_state = state;

  // Bit 7 completes a byte two edges after issue, so it waits for room in dout.
  always_comb begin
    accept     = (state == IDLE) && start && (nbytes != '0);
    issue_ok   = (issue_idx != 3'(BYTE_BITS - 1)) || !(dout_valid && !dout_ready);
    issue      = (state == READ) && issue_ok;
    last_issue = issue && (bits_left == BIT_CNT_W'(1));
    final_hs   = (state == DRAIN) && dout_valid && dout_ready && !ram_en && !rd_pending;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (nbytes == '0) ? FIN : READ;
      READ:    if (last_issue) next_state = DRAIN;
      DRAIN:   if (final_hs) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (next_state == READ) || (next_state == DRAIN);
    done_d = (next_state == FIN);
  end

  // ram_en/ram_addr describe the read the RAM samples on the next edge;
  // rd_pending marks the cycle in which that read's data sits on ram_do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en     <= 1'b0;
      ram_addr   <= '0;
      bits_left  <= '0;
      issue_idx  <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= ram_en;
      if (accept) begin
        ram_en    <= 1'b1;
        ram_addr  <= base_addr;
        bits_left <= total_bits(nbytes) - BIT_CNT_W'(1);
        issue_idx <= 3'd1;
      end else if (issue) begin
        ram_en    <= 1'b1;
        ram_addr  <= ram_addr + RAMB16_S1_AW'(1);
        bits_left <= bits_left - BIT_CNT_W'(1);
        issue_idx <= issue_idx + 3'd1;
      end else begin
        ram_en <= 1'b0;
      end
    end
  end

  bit_packer #(
    .MSB_FIRST (MSB_FIRST)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_valid  (rd_pending),
    .bit_in     (ram_do),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

endmodule

// File: tb/tb_ramb16_s1_byte_reader.sv
// Bench for ramb16_s1_byte_reader: LSB-first and MSB-first instances share one RAM image and stimulus.
module tb_ramb16_s1_byte_reader;
  import ramb16_pkg::*;

  // ---------------- clock / reset / wiring ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic [11:0] nbytes = '0;
  logic        dout_ready = 1'b0;

  logic        busy0, done0, ram_en0, ram_we0, ram_ssr0, ram_di0, ram_do0, valid0;
  logic [13:0] ram_addr0;
  logic [7:0]  dout0;
  state_t      dbg0;
  logic        busy1, done1, ram_en1, ram_we1, ram_ssr1, ram_di1, ram_do1, valid1;
  logic [13:0] ram_addr1;
  logic [7:0]  dout1;
  state_t      dbg1;

  always #5 clk = ~clk;

  ramb16_s1_byte_reader #(.MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .nbytes(nbytes),
    .busy(busy0), .done(done0), .ram_addr(ram_addr0), .ram_en(ram_en0), .ram_we(ram_we0),
    .ram_ssr(ram_ssr0), .ram_di(ram_di0), .ram_do(ram_do0), .dout(dout0),
    .dout_valid(valid0), .dout_ready(dout_ready), .dbg_state(dbg0)
  );

  ramb16_s1_byte_reader #(.MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .nbytes(nbytes),
    .busy(busy1), .done(done1), .ram_addr(ram_addr1), .ram_en(ram_en1), .ram_we(ram_we1),
    .ram_ssr(ram_ssr1), .ram_di(ram_di1), .ram_do(ram_do1), .dout(dout1),
    .dout_valid(valid1), .dout_ready(dout_ready), .dbg_state(dbg1)
  );

  // Synchronous-read RAM image shared by both instances.
  logic mem [0:16383];
  always @(posedge clk) if (ram_en0) ram_do0 <= mem[ram_addr0];
  always @(posedge clk) if (ram_en1) ram_do1 <= mem[ram_addr1];

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_msb_q[$];
  logic [13:0] addr_q[$];
  int          done_cnt = 0;
  int          iss_cnt = 0;
  int          rdy_mode = 0;
  int          stall_ctr = 0;
  bit          prev_stall = 1'b0;
  bit          last_hs_pend = 1'b0;
  logic [7:0]  prev_dout = '0;
  logic [7:0]  last_byte0 = '0;
  logic [7:0]  last_byte1 = '0;
  logic [7:0]  e_byte;
  logic [13:0] e_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: byte i of a command is bits base+8i .. base+8i+7 (mod depth),
  // weighted 2^b (LSB-first) or 2^(7-b) (MSB-first).
  task automatic prepare(input logic [13:0] base, input int n);
    int a;
    logic [7:0] lb, mb;
    for (int i = 0; i < n; i++) begin
      lb = '0;
      mb = '0;
      for (int b = 0; b < 8; b++) begin
        a = (int'(base) + i * 8 + b) % RAMB16_S1_DEPTH;
        addr_q.push_back(14'(a));
        lb = lb | (8'(mem[a]) << b);
        mb = mb | (8'(mem[a]) << (7 - b));
      end
      exp_q.push_back(lb);
      exp_msb_q.push_back(mb);
    end
  endtask

  // ---------------- consumer ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: dout_ready = 1'b1;
      1: dout_ready = 1'($urandom_range(0, 1));
      default: begin
        if (valid0 || stall_ctr > 0) stall_ctr++;
        dout_ready = (stall_ctr >= 30);
      end
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (last_hs_pend) begin
        check("done_after_last", 32'(done0), 32'd1);
        last_hs_pend = 1'b0;
      end
      if (done0) begin
        done_cnt++;
        check("busy_in_fin", 32'(busy0), 32'd0);
      end
      if (ram_en0) begin
        iss_cnt++;
        check("tieoffs", 32'({ram_we0, ram_ssr0, ram_di0}), 32'd0);
        if (addr_q.size() == 0) check("ram_en_extra", 32'(ram_en0), 32'd0);
        else begin
          e_addr = addr_q.pop_front();
          check("ram_addr", 32'(ram_addr0), 32'(e_addr));
        end
      end
      if (prev_stall) begin
        check("hold_valid", 32'(valid0), 32'd1);
        check("hold_dout", 32'(dout0), 32'(prev_dout));
      end
      if (valid0 && dout_ready) begin
        if (exp_q.size() == 0) check("byte_extra", 32'(valid0), 32'd0);
        else begin
          if (exp_q.size() == 1 && addr_q.size() == 0) last_hs_pend = 1'b1;
          e_byte = exp_q.pop_front();
          last_byte0 = dout0;
          check("dout_lsb", 32'(dout0), 32'(e_byte));
        end
      end
      if (valid1 && dout_ready) begin
        if (exp_msb_q.size() == 0) check("msb_byte_extra", 32'(valid1), 32'd0);
        else begin
          e_byte = exp_msb_q.pop_front();
          last_byte1 = dout1;
          check("dout_msb", 32'(dout1), 32'(e_byte));
        end
      end
      prev_stall = valid0 && !dout_ready;
      prev_dout  = dout0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [13:0] base, input logic [11:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; nbytes = n;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 14'($urandom); nbytes = 12'($urandom);
  endtask

  task automatic run_cmd(input logic [13:0] base, input int n, input int mode, input bit poke);
    int cyc, lat, bound;
    bit finished;
    rdy_mode = mode; stall_ctr = 0; done_cnt = 0; iss_cnt = 0;
    prepare(base, n);
    pulse_start(base, 12'(n));
    cyc = 0; lat = -1; finished = 1'b0;
    bound = n * 40 + 200;
    while (!finished && cyc < bound) begin
      @(negedge clk);
      if (valid0 && lat < 0) lat = cyc;
      if (n == 0 && cyc == 0) begin
        check("zero_done", 32'(done0), 32'd1);
        check("zero_busy", 32'(busy0), 32'd0);
      end
      if (n != 0 && cyc == 1) check("busy_high", 32'(busy0), 32'd1);
      if (mode == 2 && n >= 2 && stall_ctr == 29) begin
        check("stall_reads", 32'(iss_cnt), 32'd15);
        check("stall_en", 32'(ram_en0), 32'd0);
      end
      if (poke && n > 0 && cyc == 4) begin
        start = 1'b1; base_addr = base ^ 14'h1555; nbytes = 12'd7;
      end
      if (poke && n > 0 && cyc == 5) start = 1'b0;
      if (done0) finished = 1'b1;
      cyc++;
    end
    check("done_seen", 32'(finished), 32'd1);
    if (n != 0) check("first_latency", 32'(lat), 32'd9);
    repeat (3) @(negedge clk);
    check("done_once", 32'(done_cnt), 32'd1);
    check("reads_issued", 32'(iss_cnt), 32'(n * 8));
    check("bytes_left", 32'(exp_q.size()), 32'd0);
    check("msb_bytes_left", 32'(exp_msb_q.size()), 32'd0);
    check("addr_left", 32'(addr_q.size()), 32'd0);
    check("busy_after", 32'(busy0), 32'd0);
    exp_q.delete(); exp_msb_q.delete(); addr_q.delete();
  endtask

  task automatic reset_mid(input logic [13:0] base, input int n);
    rdy_mode = 0;
    prepare(base, n);
    pulse_start(base, 12'(n));
    repeat (12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete(); exp_msb_q.delete(); addr_q.delete();
    prev_stall = 1'b0; last_hs_pend = 1'b0; done_cnt = 0;
    #1;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_ram_en", 32'(ram_en0), 32'd0);
    check("rst_ram_addr", 32'(ram_addr0), 32'd0);
    check("rst_dout", 32'(dout0), 32'd0);
    check("rst_valid", 32'({valid1, valid0}), 32'd0);
    check("rst_state", 32'(dbg0), 32'(IDLE));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < RAMB16_S1_DEPTH; i++) mem[i] = 1'($urandom_range(0, 1));
    mem[0] = 1'b1; mem[1] = 1'b0; mem[2] = 1'b1; mem[3] = 1'b1;
    mem[4] = 1'b0; mem[5] = 1'b0; mem[6] = 1'b0; mem[7] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_done", 32'(done0), 32'd0);
    check("reset_ram_en", 32'(ram_en0), 32'd0);
    check("reset_ram_addr", 32'(ram_addr0), 32'd0);
    check("reset_dout", 32'({dout1, dout0}), 32'd0);
    check("reset_valid", 32'({valid1, valid0}), 32'd0);
    check("reset_state", 32'(dbg0), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd(14'h0000, 1, 0, 1'b0);
    check("basic_lsb", 32'(last_byte0), 32'h0D);
    check("basic_msb", 32'(last_byte1), 32'hB0);

    run_cmd(14'h3FFC, 1, 0, 1'b0);
    run_cmd(14'($urandom), 4, 2, 1'b0);
    run_cmd(14'($urandom), 0, 0, 1'b0);
    run_cmd(14'($urandom), 3, 1, 1'b1);

    for (int k = 0; k < 10; k++)
      run_cmd(14'($urandom), $urandom_range(1, 6), $urandom_range(0, 1), 1'($urandom_range(0, 1)));

    run_cmd(14'($urandom), 2049, 0, 1'b0);

    reset_mid(14'h2A10, 3);
    run_cmd(14'h0123, 2, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
